// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand sequencer.
package calc_pkg;

    localparam int unsigned BCD_W      = 13;
    localparam int unsigned BIN_W      = 11;
    localparam int unsigned MAX_DIGITS = 3;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned WAIT_W     = 3;

    typedef enum logic [2:0] {
        ENTRY_A,
        CONV_A,
        ENTRY_B,
        CONV_B,
        HOLD
    } seq_state_t;

    // Keypad events, encoded in ascending priority order.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_DIGIT,
        EV_SIGN,
        EV_ENTER,
        EV_CLEAR
    } key_evt_t;

    function automatic key_evt_t pick_event(input logic clr, input logic ent,
                                            input logic sgn, input logic dig);
        if (clr) return EV_CLEAR;
        if (ent) return EV_ENTER;
        if (sgn) return EV_SIGN;
        if (dig) return EV_DIGIT;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/calc_operand_sequencer_bcd_entry_reg.sv
// Signed 3-digit BCD entry register: digit shift, sign toggle, digit count, overflow flag.
// CALC_DIGIT_OVF_EN: drop a 4th digit and raise a sticky overflow instead of rolling it in.
module bcd_entry_reg
    import calc_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               entry_clr_i,
    input  logic               ovf_clr_i,
    input  logic               digit_en_i,
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic               sign_en_i,
    output logic [BCD_W-1:0]   entry_o,
    output logic               ovf_o
);

    localparam int unsigned MAG_W = BCD_W - 1;

    logic [BCD_W-1:0] entry_q, entry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (entry_clr_i) begin
            entry_d = '0;
            count_d = '0;
        end else if (sign_en_i) begin
            entry_d[BCD_W-1] = ~entry_q[BCD_W-1];
        end else if (digit_en_i && (digit_i <= DIGIT_W'(9))) begin
`ifdef CALC_DIGIT_OVF_EN
            if (count_q == CNT_W'(MAX_DIGITS)) begin
                ovf_d = 1'b1;
            end else begin
                entry_d[MAG_W-1:0] = {entry_q[MAG_W-DIGIT_W-1:0], digit_i};
                count_d            = count_q + CNT_W'(1);
            end
`else
            // Roll-in: the most-significant digit falls off the top.
            entry_d[MAG_W-1:0] = {entry_q[MAG_W-DIGIT_W-1:0], digit_i};
            if (count_q != CNT_W'(MAX_DIGITS)) begin
                count_d = count_q + CNT_W'(1);
            end
`endif
        end
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            entry_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign entry_o = entry_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Collects two signed BCD operands, converts each through the external converter, hands both to the ALU.
// Optional CALC_DIGIT_OVF_EN selects digit-overflow detection in the entry register.
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned CONV_WAIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               sign_toggle,
    input  logic               enter,
    input  logic               clear,
    output logic [BCD_W-1:0]   conv_operand,
    input  logic [BIN_W-1:0]   conv_result,
    output logic [BCD_W-1:0]   entry_bcd,
    output logic [BIN_W-1:0]   op_a,
    output logic [BIN_W-1:0]   op_b,
    output logic               operands_valid,
    input  logic               operands_ready,
    output logic               busy,
    output logic               entry_ovf
);

    seq_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [BIN_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic              valid_q, busy_q;

    key_evt_t          evt;
    logic              in_entry, in_conv, conv_done, leave_hold;
    logic [BCD_W-1:0]  entry_q;
    logic [BIN_W-1:0]  conv_val;

    assign evt        = pick_event(clear, enter, sign_toggle, digit_valid);
    assign in_entry   = (state_q == ENTRY_A) || (state_q == ENTRY_B);
    assign in_conv    = (state_q == CONV_A) || (state_q == CONV_B);
    assign conv_done  = in_conv && (wait_q == WAIT_W'(CONV_WAIT - 1));
    assign leave_hold = (state_q == HOLD) && operands_ready;
    // A zero magnitude is always +0, whatever sign the converter reports.
    assign conv_val   = (entry_q[BCD_W-2:0] == '0) ? '0 : conv_result;

    bcd_entry_reg u_entry (
        .clk_i       (clk),
        .reset_i     (reset),
        .entry_clr_i (clear | conv_done),
        .ovf_clr_i   (clear | leave_hold),
        .digit_en_i  (in_entry && (evt == EV_DIGIT)),
        .digit_i     (digit),
        .sign_en_i   (in_entry && (evt == EV_SIGN)),
        .entry_o     (entry_q),
        .ovf_o       (entry_ovf)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        case (state_q)
            ENTRY_A: if (evt == EV_ENTER) state_d = CONV_A;
            CONV_A: begin
                if (conv_done) begin
                    op_a_d  = conv_val;
                    wait_d  = '0;
                    state_d = ENTRY_B;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ENTRY_B: if (evt == EV_ENTER) state_d = CONV_B;
            CONV_B: begin
                if (conv_done) begin
                    op_b_d  = conv_val;
                    wait_d  = '0;
                    state_d = HOLD;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            HOLD:    if (operands_ready) state_d = ENTRY_A;
            default: state_d = ENTRY_A;
        endcase
        // Clear overrides everything and discards any partial conversion.
        if (clear) begin
            state_d = ENTRY_A;
            wait_d  = '0;
            op_a_d  = '0;
            op_b_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ENTRY_A;
            wait_q  <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            valid_q <= (state_d == HOLD);
            busy_q  <= (state_d == CONV_A) || (state_d == CONV_B) || (state_d == HOLD);
        end
    end

    assign conv_operand   = entry_q;
    assign entry_bcd      = entry_q;
    assign op_a           = op_a_q;
    assign op_b           = op_b_q;
    assign operands_valid = valid_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Self-checking bench for calc_operand_sequencer with a decimal-arithmetic reference model.
module tb_calc_operand_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT, CONV_WAIT = 1
    logic        reset, digit_valid, sign_toggle, enter, clear, operands_ready;
    logic [3:0]  digit;
    logic [12:0] conv_operand, entry_bcd;
    logic [10:0] conv_result, op_a, op_b;
    logic        operands_valid, busy, entry_ovf;

    // Second DUT, CONV_WAIT = 3
    logic        r3, dv3, st3, en3, cl3, rdy3;
    logic [3:0]  d3;
    logic [12:0] conv3, entry3;
    logic [10:0] res3, op_a3, op_b3;
    logic        valid3, busy3, ovf3;

    int checks = 0;
    int errors = 0;

    // Reference magnitude/sign of the operand being typed
    int m_mag;
    bit m_sign;
    int m_cnt;
    bit m_ovf;

    calc_operand_sequencer u_dut (
        .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
        .sign_toggle(sign_toggle), .enter(enter), .clear(clear),
        .conv_operand(conv_operand), .conv_result(conv_result), .entry_bcd(entry_bcd),
        .op_a(op_a), .op_b(op_b), .operands_valid(operands_valid),
        .operands_ready(operands_ready), .busy(busy), .entry_ovf(entry_ovf)
    );

    calc_operand_sequencer #(.CONV_WAIT(3)) u_dut3 (
        .clk(clk), .reset(r3), .digit_valid(dv3), .digit(d3),
        .sign_toggle(st3), .enter(en3), .clear(cl3),
        .conv_operand(conv3), .conv_result(res3), .entry_bcd(entry3),
        .op_a(op_a3), .op_b(op_b3), .operands_valid(valid3),
        .operands_ready(rdy3), .busy(busy3), .entry_ovf(ovf3)
    );

    // Converter model: a sign-magnitude style converter reports -0 as 11'h400.
    function automatic logic [10:0] conv_model(input logic [12:0] x);
        int mag;
        mag = int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
        if (x[12] && mag == 0) return 11'h400;
        return x[12] ? 11'(-mag) : 11'(mag);
    endfunction

    assign conv_result = conv_model(conv_operand);
    assign res3        = conv_model(conv3);

    function automatic logic [12:0] to_bcd(input bit s, input int m);
        return {s, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [10:0] to_bin(input bit s, input int m);
        return (s && m != 0) ? 11'(-m) : 11'(m);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear_entry();
        m_mag = 0; m_sign = 0; m_cnt = 0;
    endtask

    task automatic model_digit(input int d);
        if (d > 9) return;
`ifdef CALC_DIGIT_OVF_EN
        if (m_cnt == 3) m_ovf = 1;
        else begin
            m_mag = m_mag * 10 + d;
            m_cnt++;
        end
`else
        m_mag = (m_mag * 10 + d) % 1000;
        if (m_cnt < 3) m_cnt++;
`endif
    endtask

    task automatic key_digit(input int d);
        digit_valid = 1; digit = 4'(d);
        tick();
        digit_valid = 0;
        model_digit(d);
    endtask

    task automatic key_sign();
        sign_toggle = 1;
        tick();
        sign_toggle = 0;
        m_sign = ~m_sign;
    endtask

    task automatic key_enter();
        enter = 1;
        tick();
        enter = 0;
    endtask

    task automatic key_clear();
        clear = 1;
        tick();
        clear = 0;
        model_clear_entry();
        m_ovf = 0;
    endtask

    task automatic test_reset();
        reset = 1; r3 = 1;
        tick(); tick();
        reset = 0; r3 = 0;
        model_clear_entry();
        m_ovf = 0;
        checks++;
        if ({conv_operand, entry_bcd} !== 26'h0) begin
            errors++; $display("FAIL reset_entry: got %h/%h want 0", conv_operand, entry_bcd);
        end
        checks++;
        if ({op_a, op_b} !== 22'h0) begin
            errors++; $display("FAIL reset_ops: got %h/%h want 0", op_a, op_b);
        end
        checks++;
        if ({operands_valid, busy, entry_ovf} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {operands_valid, busy, entry_ovf});
        end
        checks++;
        if ({conv3, op_a3, op_b3, valid3, busy3, ovf3} !== '0) begin
            errors++; $display("FAIL reset_dut3: got %h %h %h %b%b%b want 0", conv3, op_a3, op_b3, valid3, busy3, ovf3);
        end
    endtask

    task automatic test_basic();
        key_digit(1); key_digit(2); key_digit(3);
        checks++;
        if (entry_bcd !== 13'h0123) begin
            errors++; $display("FAIL basic_entry_a: got %h want 0123", entry_bcd);
        end
        key_enter();
        checks++;
        if (busy !== 1'b1 || conv_operand !== 13'h0123) begin
            errors++; $display("FAIL basic_conv_a: busy %b operand %h want 1 0123", busy, conv_operand);
        end
        tick();
        model_clear_entry();
        checks++;
        if (op_a !== 11'h07B || busy !== 1'b0 || entry_bcd !== 13'h0) begin
            errors++; $display("FAIL basic_op_a: op_a %h busy %b entry %h want 07b 0 0", op_a, busy, entry_bcd);
        end
        key_digit(4); key_digit(5); key_sign();
        checks++;
        if (entry_bcd !== 13'h1045) begin
            errors++; $display("FAIL basic_entry_b: got %h want 1045", entry_bcd);
        end
        key_enter();
        checks++;
        if (operands_valid !== 1'b0 || conv_operand !== 13'h1045) begin
            errors++; $display("FAIL basic_conv_b: valid %b operand %h want 0 1045", operands_valid, conv_operand);
        end
        operands_ready = 1;
        tick();
        checks++;
        if (operands_valid !== 1'b1 || op_a !== 11'h07B || op_b !== 11'h7D3) begin
            errors++; $display("FAIL basic_hold: valid %b op_a %h op_b %h want 1 07b 7d3", operands_valid, op_a, op_b);
        end
        tick();
        operands_ready = 0;
        model_clear_entry();
        checks++;
        if (operands_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_release: valid %b busy %b want 0 0", operands_valid, busy);
        end
    endtask

    task automatic test_zero();
        key_enter(); tick();
        key_enter();
        tick();
        checks++;
        if (operands_valid !== 1'b1 || op_a !== 11'h0 || op_b !== 11'h0) begin
            errors++; $display("FAIL zero_ops: valid %b op_a %h op_b %h want 1 0 0", operands_valid, op_a, op_b);
        end
        operands_ready = 1; tick(); operands_ready = 0;
        key_sign(); key_enter(); tick();
        model_clear_entry();
        checks++;
        if (op_a !== 11'h0) begin
            errors++; $display("FAIL neg_zero: op_a %h want 000", op_a);
        end
        key_clear();
    endtask

    task automatic test_hold_stall();
        key_digit(1); key_digit(2); key_enter(); tick();
        model_clear_entry();
        key_digit(3); key_enter(); tick();
        model_clear_entry();
        for (int i = 0; i < 10; i++) begin
            digit_valid = 1'($urandom_range(0, 1));
            digit       = 4'($urandom_range(0, 9));
            enter       = 1'($urandom_range(0, 1));
            sign_toggle = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ({operands_valid, busy} !== 2'b11 || op_a !== 11'd12 || op_b !== 11'd3 || entry_bcd !== 13'h0) begin
                errors++;
                $display("FAIL hold_stall[%0d]: valid %b busy %b op_a %h op_b %h entry %h want 1 1 00c 003 0",
                         i, operands_valid, busy, op_a, op_b, entry_bcd);
            end
        end
        digit_valid = 0; enter = 0; sign_toggle = 0;
        operands_ready = 1; tick(); operands_ready = 0;
        checks++;
        if (operands_valid !== 1'b0 || op_a !== 11'd12) begin
            errors++; $display("FAIL hold_exit: valid %b op_a %h want 0 00c", operands_valid, op_a);
        end
    endtask

    task automatic test_overflow();
        logic [12:0] exp_e;
        logic        exp_o;
        key_clear();
        key_digit(9); key_digit(9); key_digit(9); key_digit(7);
`ifdef CALC_DIGIT_OVF_EN
        exp_e = 13'h0999; exp_o = 1'b1;
`else
        exp_e = 13'h0997; exp_o = 1'b0;
`endif
        checks++;
        if (entry_bcd !== exp_e || entry_ovf !== exp_o || entry_bcd !== to_bcd(m_sign, m_mag)) begin
            errors++; $display("FAIL overflow: entry %h ovf %b want %h %b", entry_bcd, entry_ovf, exp_e, exp_o);
        end
        key_clear();
        checks++;
        if (entry_ovf !== 1'b0 || entry_bcd !== 13'h0) begin
            errors++; $display("FAIL overflow_clear: entry %h ovf %b want 0 0", entry_bcd, entry_ovf);
        end
    endtask

    task automatic test_clear();
        key_digit(5); key_enter(); tick();
        model_clear_entry();
        key_digit(6); key_enter();
        clear = 1; tick(); clear = 0;
        model_clear_entry();
        checks++;
        if ({busy, operands_valid} !== 2'b00 || op_a !== 11'h0 || op_b !== 11'h0 || entry_bcd !== 13'h0) begin
            errors++; $display("FAIL clear_conv_b: busy %b valid %b op_a %h op_b %h entry %h want 0 0 0 0 0",
                               busy, operands_valid, op_a, op_b, entry_bcd);
        end
        tick();
        checks++;
        if (operands_valid !== 1'b0 || op_b !== 11'h0) begin
            errors++; $display("FAIL clear_no_resume: valid %b op_b %h want 0 0", operands_valid, op_b);
        end
        key_digit(7); key_enter(); tick();
        model_clear_entry();
        key_digit(8); key_enter(); tick();
        model_clear_entry();
        checks++;
        if (operands_valid !== 1'b1 || op_a !== 11'd7 || op_b !== 11'd8) begin
            errors++; $display("FAIL clear_setup_hold: valid %b op_a %h op_b %h want 1 007 008", operands_valid, op_a, op_b);
        end
        clear = 1; tick(); clear = 0;
        checks++;
        if ({busy, operands_valid} !== 2'b00 || op_a !== 11'h0) begin
            errors++; $display("FAIL clear_hold: busy %b valid %b op_a %h want 0 0 0", busy, operands_valid, op_a);
        end
        digit_valid = 1; digit = 4'd7; enter = 1;
        tick();
        digit_valid = 0; enter = 0;
        checks++;
        if (busy !== 1'b1 || conv_operand !== 13'h0) begin
            errors++; $display("FAIL enter_beats_digit: busy %b operand %h want 1 0", busy, conv_operand);
        end
        tick();
        sign_toggle = 1; digit_valid = 1; digit = 4'd4;
        tick();
        sign_toggle = 0; digit_valid = 0;
        checks++;
        if (op_a !== 11'h0 || entry_bcd !== 13'h1000) begin
            errors++; $display("FAIL sign_beats_digit: op_a %h entry %h want 0 1000", op_a, entry_bcd);
        end
        key_clear();
    endtask

    task automatic test_random();
        logic [10:0] exp_op [2];
        int          n, w;
        for (int it = 0; it < 15; it++) begin
            for (int op = 0; op < 2; op++) begin
                model_clear_entry();
                n = int'($urandom_range(0, 5));
                for (int k = 0; k < n; k++) key_digit(int'($urandom_range(0, 12)));
                if ($urandom_range(0, 1) == 1) key_sign();
                checks++;
                if (entry_bcd !== to_bcd(m_sign, m_mag)) begin
                    errors++; $display("FAIL rand_entry[%0d.%0d]: got %h want %h", it, op, entry_bcd, to_bcd(m_sign, m_mag));
                end
                exp_op[op] = to_bin(m_sign, m_mag);
                key_enter();
                if (op == 0) begin
                    tick();
                    checks++;
                    if (op_a !== exp_op[0]) begin
                        errors++; $display("FAIL rand_op_a[%0d]: got %h want %h", it, op_a, exp_op[0]);
                    end
                end
            end
            model_clear_entry();
            w = 0;
            while (operands_valid !== 1'b1 && w < 10) begin
                tick(); w++;
            end
            checks++;
            if (operands_valid !== 1'b1 || op_a !== exp_op[0] || op_b !== exp_op[1] || entry_ovf !== m_ovf) begin
                errors++; $display("FAIL rand_hold[%0d]: valid %b op_a %h op_b %h ovf %b want 1 %h %h %b",
                                   it, operands_valid, op_a, op_b, entry_ovf, exp_op[0], exp_op[1], m_ovf);
            end
            operands_ready = 1; tick(); operands_ready = 0;
            m_ovf = 0;
            checks++;
            if (operands_valid !== 1'b0 || entry_ovf !== 1'b0) begin
                errors++; $display("FAIL rand_release[%0d]: valid %b ovf %b want 0 0", it, operands_valid, entry_ovf);
            end
        end
    endtask

    task automatic test_conv_wait3();
        dv3 = 1; d3 = 4'd2; tick();
        d3 = 4'd5; tick();
        dv3 = 0;
        en3 = 1; tick(); en3 = 0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (conv3 !== 13'h0025 || op_a3 !== 11'h0 || busy3 !== 1'b1) begin
                errors++; $display("FAIL wait3_cycle[%0d]: operand %h op_a %h busy %b want 0025 000 1", k, conv3, op_a3, busy3);
            end
            tick();
        end
        checks++;
        if (op_a3 !== 11'd25 || busy3 !== 1'b0) begin
            errors++; $display("FAIL wait3_latch: op_a %h busy %b want 019 0", op_a3, busy3);
        end
        dv3 = 1; d3 = 4'd1; tick(); dv3 = 0;
        en3 = 1; tick(); en3 = 0;
        tick(); tick(); tick();
        checks++;
        if (valid3 !== 1'b1 || op_b3 !== 11'd1) begin
            errors++; $display("FAIL wait3_hold: valid %b op_b %h want 1 001", valid3, op_b3);
        end
        rdy3 = 1; tick(); rdy3 = 0;
        dv3 = 1; d3 = 4'd4; tick(); dv3 = 0;
        en3 = 1; tick(); en3 = 0;
        tick();
        r3 = 1; tick(); r3 = 0;
        checks++;
        if ({conv3, entry3, op_a3, op_b3, valid3, busy3, ovf3} !== '0) begin
            errors++; $display("FAIL wait3_reset: operand %h entry %h op_a %h op_b %h valid %b busy %b ovf %b want 0",
                               conv3, entry3, op_a3, op_b3, valid3, busy3, ovf3);
        end
        tick(); tick();
        checks++;
        if ({op_a3, valid3, busy3} !== '0) begin
            errors++; $display("FAIL wait3_no_resume: op_a %h valid %b busy %b want 0 0 0", op_a3, valid3, busy3);
        end
    endtask

    initial begin
        reset = 1; digit_valid = 0; digit = 0; sign_toggle = 0; enter = 0; clear = 0; operands_ready = 0;
        r3 = 1; dv3 = 0; d3 = 0; st3 = 0; en3 = 0; cl3 = 0; rdy3 = 0;
        test_reset();
        test_basic();
        test_zero();
        test_hold_stall();
        test_overflow();
        test_clear();
        test_random();
        test_conv_wait3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
